// File: rtl/id_ex_control_stage.sv
// Decode control and ID/EX control register for the 8-bit RISC-V pipeline.
// Define LOAD_USE_STALL_EN to enable load-use hazard detection and stalling.
module id_ex_control_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_id_instr,
    input  logic        if_id_valid,
    input  logic        flush,
    output logic        stall_if_id,
    output logic [1:0]  id_ex_alu_op,
    output logic [9:0]  id_ex_funct,
    output logic [4:0]  id_ex_rs1,
    output logic [4:0]  id_ex_rs2,
    output logic [4:0]  id_ex_rd,
    output logic        id_ex_alu_src,
    output logic        id_ex_mem_read,
    output logic        id_ex_mem_write,
    output logic        id_ex_reg_write,
    output logic        id_ex_mem_to_reg,
    output logic        id_ex_branch,
    output logic        id_ex_valid,
    output logic        illegal_instr
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [9:0] funct;

    assign opcode = if_id_instr[6:0];
    assign rs1    = if_id_instr[19:15];
    assign rs2    = if_id_instr[24:20];
    assign rd     = if_id_instr[11:7];
    assign funct  = {if_id_instr[31:25], if_id_instr[14:12]};

    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic       legal;
    logic       uses_rs2;

    always_comb begin
        alu_op     = 2'b00;
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        branch     = 1'b0;
        legal      = 1'b1;
        uses_rs2   = 1'b0;
        unique case (opcode)
            OP_R: begin
                alu_op    = 2'b10;
                reg_write = 1'b1;
                uses_rs2  = 1'b1;
            end
            OP_LD: begin
                alu_src    = 1'b1;
                mem_read   = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            OP_SD: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
                uses_rs2  = 1'b1;
            end
            OP_BEQ: begin
                alu_op   = 2'b01;
                branch   = 1'b1;
                uses_rs2 = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    logic hazard;

`ifdef LOAD_USE_STALL_EN
    assign hazard = id_ex_valid & id_ex_mem_read & (id_ex_rd != 5'd0)
                  & if_id_valid
                  & ((id_ex_rd == rs1) | (uses_rs2 & (id_ex_rd == rs2)));
`else
    assign hazard = 1'b0;
`endif

    // Flush outranks the hazard: the held instruction is being discarded anyway.
    assign stall_if_id = hazard & ~flush;

    logic issue;
    logic illegal_next;

    assign issue        = ~flush & ~hazard & if_id_valid & legal;
    assign illegal_next = ~flush & ~hazard & if_id_valid & ~legal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_ex_alu_op     <= 2'b00;
            id_ex_funct      <= 10'd0;
            id_ex_rs1        <= 5'd0;
            id_ex_rs2        <= 5'd0;
            id_ex_rd         <= 5'd0;
            id_ex_alu_src    <= 1'b0;
            id_ex_mem_read   <= 1'b0;
            id_ex_mem_write  <= 1'b0;
            id_ex_reg_write  <= 1'b0;
            id_ex_mem_to_reg <= 1'b0;
            id_ex_branch     <= 1'b0;
            id_ex_valid      <= 1'b0;
            illegal_instr    <= 1'b0;
        end else begin
            illegal_instr <= illegal_next;
            if (issue) begin
                id_ex_alu_op     <= alu_op;
                id_ex_funct      <= funct;
                id_ex_rs1        <= rs1;
                id_ex_rs2        <= rs2;
                id_ex_rd         <= rd;
                id_ex_alu_src    <= alu_src;
                id_ex_mem_read   <= mem_read;
                id_ex_mem_write  <= mem_write;
                id_ex_reg_write  <= reg_write;
                id_ex_mem_to_reg <= mem_to_reg;
                id_ex_branch     <= branch;
                id_ex_valid      <= 1'b1;
            end else begin
                id_ex_alu_op     <= 2'b00;
                id_ex_funct      <= 10'd0;
                id_ex_rs1        <= 5'd0;
                id_ex_rs2        <= 5'd0;
                id_ex_rd         <= 5'd0;
                id_ex_alu_src    <= 1'b0;
                id_ex_mem_read   <= 1'b0;
                id_ex_mem_write  <= 1'b0;
                id_ex_reg_write  <= 1'b0;
                id_ex_mem_to_reg <= 1'b0;
                id_ex_branch     <= 1'b0;
                id_ex_valid      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_control_stage.sv
// Bench for id_ex_control_stage: directed vector table, corner sequences and
// randomized traffic checked against a behavioural model.
module tb_id_ex_control_stage;

`ifdef LOAD_USE_STALL_EN
    localparam bit S = 1'b1;
`else
    localparam bit S = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        flush;
    logic        stall_if_id;
    logic [1:0]  id_ex_alu_op;
    logic [9:0]  id_ex_funct;
    logic [4:0]  id_ex_rs1;
    logic [4:0]  id_ex_rs2;
    logic [4:0]  id_ex_rd;
    logic        id_ex_alu_src;
    logic        id_ex_mem_read;
    logic        id_ex_mem_write;
    logic        id_ex_reg_write;
    logic        id_ex_mem_to_reg;
    logic        id_ex_branch;
    logic        id_ex_valid;
    logic        illegal_instr;

    id_ex_control_stage dut (
        .clk(clk),
        .reset(reset),
        .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid),
        .flush(flush),
        .stall_if_id(stall_if_id),
        .id_ex_alu_op(id_ex_alu_op),
        .id_ex_funct(id_ex_funct),
        .id_ex_rs1(id_ex_rs1),
        .id_ex_rs2(id_ex_rs2),
        .id_ex_rd(id_ex_rd),
        .id_ex_alu_src(id_ex_alu_src),
        .id_ex_mem_read(id_ex_mem_read),
        .id_ex_mem_write(id_ex_mem_write),
        .id_ex_reg_write(id_ex_reg_write),
        .id_ex_mem_to_reg(id_ex_mem_to_reg),
        .id_ex_branch(id_ex_branch),
        .id_ex_valid(id_ex_valid),
        .illegal_instr(illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [1:0] alu_op;
        logic [9:0] funct;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
        logic       valid;
        logic       illegal;
    } state_t;

    typedef struct {
        logic [31:0] instr;
        logic        v;
        logic        f;
        logic        stall;
        logic [1:0]  alu;
        logic [9:0]  funct;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        br;
        logic        vo;
        logic        il;
    } vec_t;

    function automatic vec_t mk(logic [31:0] instr, logic v, logic f,
                                logic stall, logic [1:0] alu,
                                logic [9:0] funct, logic [4:0] rd,
                                logic rw, logic mr, logic br,
                                logic vo, logic il);
        vec_t r;
        r.instr = instr; r.v = v; r.f = f; r.stall = stall;
        r.alu = alu; r.funct = funct; r.rd = rd;
        r.rw = rw; r.mr = mr; r.br = br; r.vo = vo; r.il = il;
        return r;
    endfunction

    function automatic state_t dut_state();
        state_t s;
        s = {id_ex_alu_op, id_ex_funct, id_ex_rs1, id_ex_rs2, id_ex_rd,
             id_ex_alu_src, id_ex_mem_read, id_ex_mem_write,
             id_ex_reg_write, id_ex_mem_to_reg, id_ex_branch,
             id_ex_valid, illegal_instr};
        return s;
    endfunction

    task automatic check_bit(string name, logic act, logic req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_state(string name, state_t act, state_t req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: ID/EX contents derived straight from the decode table.
    state_t m;

    function automatic state_t model_next(state_t cur, logic [31:0] ins,
                                          logic v, logic f,
                                          output logic stall);
        state_t n;
        logic [6:0] op;
        logic legal, uses2, hz;
        n = '0;
        op = ins[6:0];
        legal = (op == 7'h33) || (op == 7'h03) || (op == 7'h23) || (op == 7'h63);
        uses2 = (op == 7'h33) || (op == 7'h23) || (op == 7'h63);
        hz = S && cur.valid && cur.mem_read && (cur.rd != 0) && v &&
             ((cur.rd == ins[19:15]) || (uses2 && cur.rd == ins[24:20]));
        stall = hz && !f;
        if (f || hz || !v) return n;
        if (!legal) begin
            n.illegal = 1'b1;
            return n;
        end
        n.funct = {ins[31:25], ins[14:12]};
        n.rs1 = ins[19:15];
        n.rs2 = ins[24:20];
        n.rd = ins[11:7];
        n.valid = 1'b1;
        case (op)
            7'h33: begin n.alu_op = 2'b10; n.reg_write = 1; end
            7'h03: begin
                n.alu_src = 1; n.mem_read = 1; n.reg_write = 1; n.mem_to_reg = 1;
            end
            7'h23: begin n.alu_src = 1; n.mem_write = 1; end
            default: begin n.alu_op = 2'b01; n.branch = 1; end
        endcase
        return n;
    endfunction

    vec_t vecs[19];

    initial begin
        logic st;
        state_t nx;
        logic [31:0] ins;
        logic [6:0] ops[5];

        vecs[0]  = mk(32'h002081B3,1,0,0,2'b10,10'd0,5'd3,1,0,0,1,0);
        vecs[1]  = mk(32'h402081B3,1,0,0,2'b10,10'b0100000000,5'd3,1,0,0,1,0);
        vecs[2]  = mk(32'h00208063,1,0,0,2'b01,10'd0,5'd0,0,0,1,1,0);
        vecs[3]  = mk(32'h0000B283,1,0,0,2'b00,10'd3,5'd5,1,1,0,1,0);
        vecs[4]  = S ? mk(32'h00228333,1,0,1,2'b00,10'd0,5'd0,0,0,0,0,0)
                     : mk(32'h00228333,1,0,0,2'b10,10'd0,5'd6,1,0,0,1,0);
        vecs[5]  = mk(32'h00228333,1,0,0,2'b10,10'd0,5'd6,1,0,0,1,0);
        vecs[6]  = mk(32'h0000B283,1,0,0,2'b00,10'd3,5'd5,1,1,0,1,0);
        vecs[7]  = mk(32'h00228333,1,1,0,2'b00,10'd0,5'd0,0,0,0,0,0);
        vecs[8]  = mk(32'h0000007F,1,0,0,2'b00,10'd0,5'd0,0,0,0,0,1);
        vecs[9]  = mk(32'h00000000,0,0,0,2'b00,10'd0,5'd0,0,0,0,0,0);
        vecs[10] = mk(32'h0000B003,1,0,0,2'b00,10'd3,5'd0,1,1,0,1,0);
        vecs[11] = mk(32'h00200333,1,0,0,2'b10,10'd0,5'd6,1,0,0,1,0);
        vecs[12] = mk(32'h0000B283,1,0,0,2'b00,10'd3,5'd5,1,1,0,1,0);
        vecs[13] = S ? mk(32'h0002B283,1,0,1,2'b00,10'd0,5'd0,0,0,0,0,0)
                     : mk(32'h0002B283,1,0,0,2'b00,10'd3,5'd5,1,1,0,1,0);
        vecs[14] = mk(32'h0002B283,1,0,0,2'b00,10'd3,5'd5,1,1,0,1,0);
        vecs[15] = S ? mk(32'h00228333,1,0,1,2'b00,10'd0,5'd0,0,0,0,0,0)
                     : mk(32'h00228333,1,0,0,2'b10,10'd0,5'd6,1,0,0,1,0);
        vecs[16] = mk(32'h0000007F,1,1,0,2'b00,10'd0,5'd0,0,0,0,0,0);
        vecs[17] = mk(32'h0000007F,0,0,0,2'b00,10'd0,5'd0,0,0,0,0,0);
        vecs[18] = mk(32'h0020B023,1,0,0,2'b00,10'd3,5'd0,0,0,0,1,0);

        reset = 1'b1;
        if_id_instr = '0;
        if_id_valid = 1'b0;
        flush = 1'b0;
        #12;
        check_state("reset_state", dut_state(), '0);
        check_bit("reset_stall", stall_if_id, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            if_id_instr = vecs[i].instr;
            if_id_valid = vecs[i].v;
            flush = vecs[i].f;
            #1;
            check_bit($sformatf("vec%0d_stall", i), stall_if_id, vecs[i].stall);
            @(posedge clk);
            #1;
            n_checks++;
            if ({id_ex_alu_op, id_ex_funct, id_ex_rd, id_ex_reg_write,
                 id_ex_mem_read, id_ex_branch, id_ex_valid, illegal_instr} !==
                {vecs[i].alu, vecs[i].funct, vecs[i].rd, vecs[i].rw,
                 vecs[i].mr, vecs[i].br, vecs[i].vo, vecs[i].il}) begin
                n_fail++;
                $display("FAIL vec%0d_out: got alu=%b funct=%b rd=%0d rw=%b mr=%b br=%b v=%b il=%b expected alu=%b funct=%b rd=%0d rw=%b mr=%b br=%b v=%b il=%b",
                         i, id_ex_alu_op, id_ex_funct, id_ex_rd, id_ex_reg_write,
                         id_ex_mem_read, id_ex_branch, id_ex_valid, illegal_instr,
                         vecs[i].alu, vecs[i].funct, vecs[i].rd, vecs[i].rw,
                         vecs[i].mr, vecs[i].br, vecs[i].vo, vecs[i].il);
            end
        end

        // Asynchronous reset between edges, in the middle of a load-use stall.
        @(negedge clk);
        if_id_instr = 32'h0000B283;
        if_id_valid = 1'b1;
        flush = 1'b0;
        @(posedge clk);
        #1;
        check_bit("pre_reset_valid", id_ex_valid, 1'b1);
        @(negedge clk);
        if_id_instr = 32'h00228333;
        #1;
        check_bit("mid_stall_stall", stall_if_id, S);
        reset = 1'b1;
        #1;
        check_state("async_reset_state", dut_state(), '0);
        check_bit("async_reset_stall", stall_if_id, 1'b0);
        @(posedge clk);
        #1;
        check_state("held_reset_state", dut_state(), '0);
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic against the model, registers drawn from x0..x3.
        ops[0] = 7'h33; ops[1] = 7'h03; ops[2] = 7'h23; ops[3] = 7'h63;
        ops[4] = 7'h00;
        m = '0;
        for (int k = 0; k < 400; k++) begin
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 4)];
            if (ins[6:0] == 7'h00) ins[6:0] = 7'($urandom);
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            ins[11:7]  = 5'($urandom_range(0, 3));
            if_id_instr = ins;
            if_id_valid = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 9) == 0);
            nx = model_next(m, ins, if_id_valid, flush, st);
            #1;
            check_bit($sformatf("rnd%0d_stall", k), stall_if_id, st);
            @(posedge clk);
            #1;
            m = nx;
            check_state($sformatf("rnd%0d_state", k), dut_state(), m);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
